truth_table_evaluator: RTL and testbench



---
 rtl/evo_eval_pkg.sv | 15 +
 rtl/truth_table_evaluator_popcount4.sv | 8 +
 rtl/truth_table_evaluator.sv | 113 +++++++++++
 tb/tb_truth_table_evaluator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/evo_eval_pkg.sv
// Shared types and sizes for the truth-table fitness evaluator.
package evo_eval_pkg;
   localparam int NUM_IN  = 4;
   localparam int NUM_OUT = 4;
   localparam int NUM_VEC = 16;
   localparam int TABLE_W = 64;
   localparam int FIT_W   = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;
endpackage

// File: rtl/truth_table_evaluator_popcount4.sv
// Number of set bits in a 4-bit mismatch vector.
module popcount4 (
   input  logic [3:0] i_bits,
   output logic [2:0] o_count
);
   assign o_count = {2'b00, i_bits[0]} + {2'b00, i_bits[1]}
                  + {2'b00, i_bits[2]} + {2'b00, i_bits[3]};
endmodule

// File: rtl/truth_table_evaluator.sv
// Sweeps all 16 input vectors through an external candidate circuit
// and scores its outputs against a target truth table.
module truth_table_evaluator
   import evo_eval_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [TABLE_W-1:0] i_target_table,
   input  logic [NUM_OUT-1:0] i_cand_out,
   output logic [NUM_IN-1:0]  o_cand_in,
   output logic               o_busy,
   output logic               o_done,
   output logic [FIT_W-1:0]   o_fitness,
   output logic [NUM_OUT-1:0] o_err_mask,
   output logic               o_perfect
);
   localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

   state_t               r_state;
   logic [TABLE_W-1:0]   r_table;
   logic [3:0]           r_vec;
   logic [7:0]           r_cnt;
   logic [FIT_W-1:0]     r_score;
   logic [NUM_OUT-1:0]   r_err;
   logic [NUM_IN-1:0]    r_cand_in;
   logic                 r_busy;
   logic                 r_done;
   logic [FIT_W-1:0]     r_fitness;
   logic [NUM_OUT-1:0]   r_err_mask;
   logic                 r_perfect;

   logic [NUM_OUT-1:0]   w_mismatch;
   logic [2:0]           w_pop;
   logic [2:0]           w_inc;

   assign w_mismatch = i_cand_out ^ r_table[{r_vec, 2'b00} +: NUM_OUT];
   assign w_inc      = 3'd4 - w_pop;

   popcount4 u_pop (
      .i_bits  (w_mismatch),
      .o_count (w_pop)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_table    <= '0;
         r_vec      <= '0;
         r_cnt      <= '0;
         r_score    <= '0;
         r_err      <= '0;
         r_cand_in  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fitness  <= '0;
         r_err_mask <= '0;
         r_perfect  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_table   <= i_target_table;
                  r_vec     <= '0;
                  r_cand_in <= '0;
                  r_cnt     <= '0;
                  r_score   <= '0;
                  r_err     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_SETTLE;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            S_SETTLE: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == LP_LAST) r_state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               r_score <= r_score + {4'b0000, w_inc};
               r_err   <= r_err | w_mismatch;
               if (r_vec == 4'd15) begin
                  r_state <= S_DONE;
               end else begin
                  r_vec     <= r_vec + 4'd1;
                  r_cand_in <= r_vec + 4'd1;
                  r_cnt     <= '0;
                  r_state   <= S_SETTLE;
               end
            end
            S_DONE: begin
               // busy stays high into the cycle where done is visible
               r_done     <= 1'b1;
               r_fitness  <= r_score;
               r_err_mask <= r_err;
               r_perfect  <= (r_score == 7'd64);
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_cand_in  = r_cand_in;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_fitness  = r_fitness;
   assign o_err_mask = r_err_mask;
   assign o_perfect  = r_perfect;
endmodule

// File: tb/tb_truth_table_evaluator.sv
// Directed bench: identity and delayed candidates, mid-run start/table
// changes, reset abort and back-to-back runs.
module tb_truth_table_evaluator;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [63:0] tt_a, tt_b;
   logic [3:0]  co_a, co_b, ci_a, ci_b;
   logic        busy_a, done_a, perf_a;
   logic        busy_b, done_b, perf_b;
   logic [6:0]  fit_a, fit_b;
   logic [3:0]  em_a, em_b;
   logic        sel_dly;
   logic [15:0] dly_a, dly_b;
   int          checks = 0;
   int          failures = 0;

   localparam logic [63:0] IDENT = 64'hFEDCBA9876543210;

   always #5 clk = ~clk;

   // candidate models: identity or a 4-register pipeline
   always @(posedge clk) begin
      dly_a <= {dly_a[11:0], ci_a};
      dly_b <= {dly_b[11:0], ci_b};
   end
   assign co_a = sel_dly ? dly_a[15:12] : ci_a;
   assign co_b = dly_b[15:12];

   truth_table_evaluator #(.SETTLE_CYCLES(4)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a),
      .i_target_table(tt_a), .i_cand_out(co_a),
      .o_cand_in(ci_a), .o_busy(busy_a), .o_done(done_a),
      .o_fitness(fit_a), .o_err_mask(em_a), .o_perfect(perf_a)
   );

   truth_table_evaluator #(.SETTLE_CYCLES(2)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b),
      .i_target_table(tt_b), .i_cand_out(co_b),
      .o_cand_in(ci_b), .o_busy(busy_b), .o_done(done_b),
      .o_fitness(fit_b), .o_err_mask(em_b), .o_perfect(perf_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_a(input int pulse_at, input int flip_at,
                        output int dcyc, output int nd);
      dcyc = -1;
      nd = 0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int n = 1; n <= 120; n++) begin
         start_a = (n == pulse_at);
         if (n == flip_at) tt_a = '1;
         @(posedge clk); #1;
         if (done_a) begin
            nd++;
            if (dcyc < 0) dcyc = n;
         end
         if (n == 1) chk("busy_run", busy_a, 1);
         if (n == 82) chk("busy_idle", busy_a, 0);
      end
      start_a = 1'b0;
   endtask

   int dc, nd, d1, d2;

   initial begin
      rst = 1'b1; start_a = 0; start_b = 0;
      tt_a = '0; tt_b = '0; sel_dly = 0;
      dly_a = '0; dly_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_fit", fit_a, 0);
      chk("rst_err", em_a, 0);
      chk("rst_perf", perf_a, 0);
      chk("rst_cand", ci_a, 0);
      rst = 1'b0;

      // identity candidate, identity target
      tt_a = IDENT;
      run_a(0, 0, dc, nd);
      chk("id_lat", dc, 81);
      chk("id_ndone", nd, 1);
      chk("id_fit", fit_a, 64);
      chk("id_perf", perf_a, 1);
      chk("id_err", em_a, 0);

      // delayed candidate, long enough settle
      sel_dly = 1'b1;
      run_a(0, 0, dc, nd);
      chk("dly4_fit", fit_a, 64);
      chk("dly4_lat", dc, 81);
      sel_dly = 1'b0;

      // delayed candidate, too short settle: sees previous vector
      tt_b = IDENT;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      dc = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (done_b && dc < 0) dc = n;
      end
      chk("dly2_lat", dc, 49);
      chk("dly2_fit", fit_b, 38);
      chk("dly2_err", em_b, 4'hF);
      chk("dly2_perf", perf_b, 0);

      // identity candidate, all-zero target
      tt_a = '0;
      run_a(0, 0, dc, nd);
      chk("zero_fit", fit_a, 32);
      chk("zero_err", em_a, 4'hF);
      chk("zero_perf", perf_a, 0);

      // start while busy and target change mid-run are ignored
      tt_a = IDENT;
      run_a(20, 30, dc, nd);
      chk("mid_lat", dc, 81);
      chk("mid_ndone", nd, 1);
      chk("mid_fit", fit_a, 64);
      chk("mid_err", em_a, 0);

      // reset mid-run
      tt_a = IDENT;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_cand", ci_a, 0);
      chk("abort_fit", fit_a, 0);
      chk("abort_done", done_a, 0);
      nd = 0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #1;
         if (done_a) nd++;
      end
      chk("abort_nodone", nd, 0);
      run_a(0, 0, dc, nd);
      chk("rerun_lat", dc, 81);
      chk("rerun_fit", fit_a, 64);

      // back-to-back with start held high
      tt_a = '0;
      start_a = 1'b1;
      @(posedge clk); #1;
      tt_a = IDENT;
      d1 = -1; d2 = -1; nd = 0;
      for (int n = 1; n <= 170; n++) begin
         @(posedge clk); #1;
         if (done_a) begin
            nd++;
            if (d1 < 0) d1 = n;
            else if (d2 < 0) d2 = n;
         end
         if (n == 120) chk("b2b_hold", fit_a, 32);
      end
      chk("b2b_first", d1, 81);
      chk("b2b_second", d2, 163);
      chk("b2b_ndone", nd, 2);
      chk("b2b_fit2", fit_a, 64);
      start_a = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
